pdp_instr_decode: RTL

- Instruction fetch/decode stage of the PDP-8 core, between the memory subsystem and the execution unit.
- Fetches one 12-bit word per instruction at the address in the execution unit's PC.
- Decodes the word into one-hot memory-reference or group-7 (op7) opcode structs and holds them until the execution unit releases stall.
- Clears all opcodes between instructions so consumers see a clean rising edge per instruction.

---
 rtl/pdp_instr_decode_if.sv | 17 +
 rtl/pdp_instr_decode.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp_instr_decode_if.sv
// pdp_instr_decode_if -- instruction-fetch read bus between the decode stage
// and the memory subsystem.
//   ifu_rd_req  : single-cycle read strobe (decode -> memory)
//   ifu_rd_addr : read address, valid while ifu_rd_req is high
//   ifu_rd_data : read data, sampled RD_LATENCY cycles after the strobe
// master = fetch/decode side, slave = memory side.
interface pdp_instr_decode_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 12
);
   logic                  ifu_rd_req;
   logic [ADDR_WIDTH-1:0] ifu_rd_addr;
   logic [DATA_WIDTH-1:0] ifu_rd_data;

   modport master (output ifu_rd_req, output ifu_rd_addr, input ifu_rd_data);
   modport slave  (input ifu_rd_req, input ifu_rd_addr, output ifu_rd_data);
endinterface

// File: rtl/pdp_instr_decode.sv
// pdp_instr_decode -- PDP-8 instruction fetch/decode stage.
// Fetches one word per instruction at PC_value (START_ADDR for the first
// fetch after reset), decodes it into one-hot opcode structs, holds them
// while the execution unit stalls, then clears them before the next fetch.
//
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   ifu                : read bus (pdp_instr_decode_if.master)
//   base_addr          : address of the first instruction (START_ADDR)
//   pdp_mem_opcode     : AND/TAD/ISZ/DCA/JMS/JMP flags + mem_inst_addr
//   pdp_op7_opcode     : one-hot group-7 flags (NOP for unknown/IOT words)
//   stall              : execution unit busy; holds the opcodes
//   PC_value           : current program counter, used as fetch address
//   instr_count,
//   stall_cycles       : saturating performance counters, present only
//                        when IFD_PERF_CNT_EN is defined
// RD_LATENCY legal range: 1..4.

package pdp_instr_decode_pkg;
   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 12;

   localparam logic [11:0] OP7_IAC     = 12'o7001;
   localparam logic [11:0] OP7_RAL     = 12'o7004;
   localparam logic [11:0] OP7_RTL     = 12'o7006;
   localparam logic [11:0] OP7_RAR     = 12'o7010;
   localparam logic [11:0] OP7_RTR     = 12'o7012;
   localparam logic [11:0] OP7_CML     = 12'o7020;
   localparam logic [11:0] OP7_CMA     = 12'o7040;
   localparam logic [11:0] OP7_CIA     = 12'o7041;
   localparam logic [11:0] OP7_CLL     = 12'o7100;
   localparam logic [11:0] OP7_CLA1    = 12'o7200;
   localparam logic [11:0] OP7_CLA_CLL = 12'o7300;
   localparam logic [11:0] OP7_HLT     = 12'o7402;
   localparam logic [11:0] OP7_OSR     = 12'o7404;
   localparam logic [11:0] OP7_SKP     = 12'o7410;
   localparam logic [11:0] OP7_SNL     = 12'o7420;
   localparam logic [11:0] OP7_SZL     = 12'o7430;
   localparam logic [11:0] OP7_SZA     = 12'o7440;
   localparam logic [11:0] OP7_SNA     = 12'o7450;
   localparam logic [11:0] OP7_SMA     = 12'o7500;
   localparam logic [11:0] OP7_SPA     = 12'o7510;
   localparam logic [11:0] OP7_CLA2    = 12'o7600;
   localparam logic [11:0] OP7_NOP     = 12'o7000;

   typedef struct packed {
      logic       AND;
      logic       TAD;
      logic       ISZ;
      logic       DCA;
      logic       JMS;
      logic       JMP;
      logic [8:0] mem_inst_addr;
   } pdp_mem_opcode_s;

   typedef struct packed {
      logic NOP;
      logic IAC;
      logic RAL;
      logic RTL;
      logic RAR;
      logic RTR;
      logic CML;
      logic CMA;
      logic CIA;
      logic CLL;
      logic CLA1;
      logic CLA_CLL;
      logic HLT;
      logic OSR;
      logic SKP;
      logic SNL;
      logic SZL;
      logic SZA;
      logic SNA;
      logic SMA;
      logic SPA;
      logic CLA2;
   } pdp_op7_opcode_s;
endpackage

// state  | meaning
// IDLE   | one cycle after reset release, arms the first fetch
// FETCH  | ifu_rd_req high, address presented
// WAIT   | RD_LATENCY cycles, read data captured on the last one
// DECODE | captured word decoded into the opcode registers
// EXEC   | opcodes held while stall is high
// CLEAR  | opcodes zero, next fetch follows
module pdp_instr_decode
   import pdp_instr_decode_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o200,
   parameter int                    RD_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   pdp_instr_decode_if.master     ifu,
   output logic [ADDR_WIDTH-1:0]  base_addr,
   output pdp_mem_opcode_s        pdp_mem_opcode,
   output pdp_op7_opcode_s        pdp_op7_opcode,
   input  logic                   stall,
   input  logic [ADDR_WIDTH-1:0]  PC_value
`ifdef IFD_PERF_CNT_EN
   ,
   output logic [31:0]            instr_count,
   output logic [31:0]            stall_cycles
`endif
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, DECODE, EXEC, CLEAR} state_e;

   localparam logic [1:0] WAIT_LOAD = 2'(RD_LATENCY - 1);

   state_e                 state_q, state_d;
   logic                   first_q, first_d;
   logic [1:0]             wait_q, wait_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]  base_q;
   logic [DATA_WIDTH-1:0]  word_q, word_d;
   pdp_mem_opcode_s        mem_q, mem_d, mem_dec;
   pdp_op7_opcode_s        op7_q, op7_d, op7_dec;
   logic [ADDR_WIDTH-1:0]  fetch_addr;

   assign fetch_addr       = first_q ? START_ADDR : PC_value;
   assign ifu.ifu_rd_req   = (state_q == FETCH);
   assign ifu.ifu_rd_addr  = (state_q == FETCH) ? fetch_addr : addr_q;
   assign base_addr        = base_q;
   assign pdp_mem_opcode   = mem_q;
   assign pdp_op7_opcode   = op7_q;

   always_comb begin
      mem_dec = '0;
      op7_dec = '0;
      case (word_q[11:9])
         3'o0: mem_dec.AND = 1'b1;
         3'o1: mem_dec.TAD = 1'b1;
         3'o2: mem_dec.ISZ = 1'b1;
         3'o3: mem_dec.DCA = 1'b1;
         3'o4: mem_dec.JMS = 1'b1;
         3'o5: mem_dec.JMP = 1'b1;
         3'o7: begin
            case (word_q)
               OP7_IAC:     op7_dec.IAC     = 1'b1;
               OP7_RAL:     op7_dec.RAL     = 1'b1;
               OP7_RTL:     op7_dec.RTL     = 1'b1;
               OP7_RAR:     op7_dec.RAR     = 1'b1;
               OP7_RTR:     op7_dec.RTR     = 1'b1;
               OP7_CML:     op7_dec.CML     = 1'b1;
               OP7_CMA:     op7_dec.CMA     = 1'b1;
               OP7_CIA:     op7_dec.CIA     = 1'b1;
               OP7_CLL:     op7_dec.CLL     = 1'b1;
               OP7_CLA1:    op7_dec.CLA1    = 1'b1;
               OP7_CLA_CLL: op7_dec.CLA_CLL = 1'b1;
               OP7_HLT:     op7_dec.HLT     = 1'b1;
               OP7_OSR:     op7_dec.OSR     = 1'b1;
               OP7_SKP:     op7_dec.SKP     = 1'b1;
               OP7_SNL:     op7_dec.SNL     = 1'b1;
               OP7_SZL:     op7_dec.SZL     = 1'b1;
               OP7_SZA:     op7_dec.SZA     = 1'b1;
               OP7_SNA:     op7_dec.SNA     = 1'b1;
               OP7_SMA:     op7_dec.SMA     = 1'b1;
               OP7_SPA:     op7_dec.SPA     = 1'b1;
               OP7_CLA2:    op7_dec.CLA2    = 1'b1;
               default:     op7_dec.NOP     = 1'b1;
            endcase
         end
         default: op7_dec.NOP = 1'b1;   // IOT
      endcase
      if (word_q[11:9] <= 3'o5) mem_dec.mem_inst_addr = word_q[8:0];
   end

   always_comb begin
      state_d = state_q;
      first_d = first_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      word_d  = word_q;
      mem_d   = mem_q;
      op7_d   = op7_q;
      case (state_q)
         IDLE: begin
            first_d = 1'b1;
            state_d = FETCH;
         end
         FETCH: begin
            addr_d  = fetch_addr;
            wait_d  = WAIT_LOAD;
            state_d = WAIT;
         end
         WAIT: begin
            if (wait_q == 2'd0) begin
               // undriven/unknown memory data becomes a NOP word
               word_d  = $isunknown(ifu.ifu_rd_data) ? OP7_NOP : ifu.ifu_rd_data;
               state_d = DECODE;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         DECODE: begin
            mem_d   = mem_dec;
            op7_d   = op7_dec;
            first_d = 1'b0;
            state_d = EXEC;
         end
         EXEC: begin
            // clear on the way out so the opcodes are already zero in CLEAR
            if (!stall) begin
               mem_d   = '0;
               op7_d   = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            mem_d   = '0;
            op7_d   = '0;
            state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         first_q <= 1'b0;
         wait_q  <= '0;
         addr_q  <= '0;
         base_q  <= START_ADDR;
         word_q  <= OP7_NOP;
         mem_q   <= '0;
         op7_q   <= '0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         base_q  <= base_q;
         word_q  <= word_d;
         mem_q   <= mem_d;
         op7_q   <= op7_d;
      end
   end

`ifdef IFD_PERF_CNT_EN
   logic [31:0] icnt_q, icnt_d;
   logic [31:0] scnt_q, scnt_d;

   always_comb begin
      icnt_d = icnt_q;
      scnt_d = scnt_q;
      if (state_q == DECODE && icnt_q != '1)         icnt_d = icnt_q + 32'd1;
      if (state_q == EXEC && stall && scnt_q != '1)  scnt_d = scnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         icnt_q <= '0;
         scnt_q <= '0;
      end else begin
         icnt_q <= icnt_d;
         scnt_q <= scnt_d;
      end
   end

   assign instr_count  = icnt_q;
   assign stall_cycles = scnt_q;
`endif

endmodule
